clk_divider_prog: RTL and testbench
===================================

# clk_divider_prog

Runtime-programmable integer clock divider producing a 50 %-duty `clk_out` for any ratio from 2 to 2^DIV_W−1, odd or even. Ratio changes are glitch-free and take effect only at output-period boundaries. An enable drains the current period cleanly before stopping. The block sits in the clock-generation area, driven by the reference clock, and feeds local derived-clock consumers plus a period tick for same-domain logic.

## Interface
- `DIV_W`, 8: width of ratio fields.
- `DEFAULT_DIV`, 5: ratio loaded at reset; must be in 2..2^DIV_W−1.
- `clk_in`  in  1: reference clock; all state on posedge except the odd-ratio negedge flop.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: run request, level.
- `div_load`  in  1: one-cycle strobe; samples `div_ratio`.
- `div_ratio`  in  DIV_W: requested ratio N.
- `clk_out`  out  1: divided clock.
- `period_tick`  out  1: one `clk_in` cycle pulse at each `clk_out` rising edge.
- `div_active`  out  DIV_W: ratio currently in use.
- `cfg_pending`  out  1: accepted ratio waiting for a boundary.
- `cfg_err`  out  1: one-cycle pulse; rejected load (`div_ratio` < 2).
- `running`  out  1: high in RUN and STOP.

## Operation
- Reset values:
  - `clk_out` = 0, `period_tick` = 0, `cfg_pending` = 0, `cfg_err` = 0, `running` = 0.
  - `div_active` = DEFAULT_DIV, counter `cnt` = 0, state IDLE.
  - Negedge flop also cleared asynchronously.
- Counter: `cnt` runs 0..N−1 and wraps to 0. Each wrap to 0, or entry into RUN, is a period start.
- High-time H = N>>1.
  - Posedge flop `pos_q` is 1 while `cnt` < H.
  - Negedge flop `neg_q` samples `pos_q` on the falling edge.
  - Even N: `clk_out` = `pos_q`.
  - Odd N: `clk_out` = `pos_q` | `neg_q`, giving a high time of N/2 `clk_in` periods.
- States:
  - IDLE: `cnt` held at 0, `clk_out` low.
    - `en`=1 → RUN. The next posedge is a period start.
  - RUN: counting.
    - `en`=0 → STOP. The current period completes.
  - STOP: counting to N−1.
    - At wrap → IDLE, unless `en`=1 at that posedge; then stay in RUN with no gap.
- Loads:
  - `div_load` with `div_ratio` ≥ 2: store in pending register, set `cfg_pending`.
  - A second load while pending overwrites; last value wins.
  - `div_ratio` < 2: `cfg_err` pulses the next cycle; pending and active are unchanged.
- Apply: at a period start, or on IDLE→RUN entry, if `cfg_pending`, copy pending to `div_active` and clear `cfg_pending`. The new N governs that whole period.
- Load coincident with a wrap: it is stored and applied at the following boundary, never mid-period.
- Load while IDLE: applied at the next RUN entry.
- `cnt` width is DIV_W. Comparisons are unsigned; there is no overflow at N = 2^DIV_W−1.

## Timing
- `clk_out` rising edge coincides with the `clk_in` posedge of the period start. Latency from `en` rising to first `clk_out` rise is 1 `clk_in` cycle.
- `period_tick` is registered and high during the first `clk_in` cycle of each period.
- `cfg_err` is registered, 1 cycle after the strobe.
- Output period is exactly N `clk_in` cycles. No runt pulse at a ratio change, at start, or at stop.
- Reset asserted mid-period forces `clk_out` low immediately; this is the only permitted truncated high.
- After `rst_n` deasserts with `en` high, the first period starts on the second posedge: one posedge is spent leaving reset (IDLE→RUN).

## Configuration
- `CLKDIV_NEGEDGE_EN` defined: negedge flop present, odd-ratio duty is exactly 50 %.
- Not defined: no negedge logic, `clk_out` = `pos_q` for all N. Odd N then has a high time of (N−1)/2 cycles. Period and tick behaviour are unchanged.

## Test plan
- Reset, `en`=1, DEFAULT_DIV=5, macro on → `clk_out` period 5 cycles, high 2.5 cycles; `period_tick` every 5 cycles; `div_active`=5.
- Load 4 mid-period → current period still 5; next period is 4 cycles, high 2; `cfg_pending` high until that boundary.
- Loads 6 then 3 within one period → only 3 applied; period 3, high 1.5 cycles.
- Load 1 → `cfg_err` pulses once; `div_active` stays 5; `cfg_pending` stays 0.
- `en` dropped at `cnt`=1 with N=5 → period completes to `cnt`=4; `clk_out` stays low; `running`=0 after wrap. Re-raise `en` → first rise 1 cycle later.
- Macro off, N=7 → high 3 cycles, low 4; `rst_n` pulled low mid-high → `clk_out`=0 immediately.

Source files
------------

// File: rtl/clk_divider_prog.sv
// Programmable integer clock divider with 50%-duty output, boundary-aligned ratio changes and clean stop.
// Define CLKDIV_NEGEDGE_EN to add the falling-edge flop that gives exact 50% duty on odd ratios.
module clk_divider_prog #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_ratio,
  output logic             clk_out,
  output logic             period_tick,
  output logic [DIV_W-1:0] div_active,
  output logic             cfg_pending,
  output logic             cfg_err,
  output logic             running
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_e;

  state_e           state_q, state_d;
  logic             start_q, start_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             pos_q, pos_d;
  logic             tick_q, tick_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             err_q, err_d;

  logic wrap, pstart, counting, apply, load_ok;

  // start_q marks the single cycle between IDLE->RUN entry and the first period start
  assign wrap = (cnt_q == act_q - DIV_W'(1));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    pstart  = 1'b0;
    case (state_q)
      IDLE: if (en) begin
        state_d = RUN;
        start_d = 1'b1;
      end
      RUN: begin
        if (start_q || wrap) begin
          if (en) pstart  = 1'b1;
          else    state_d = IDLE;
        end else if (!en) begin
          state_d = STOP;
        end
      end
      STOP: if (wrap) begin
        if (en) begin
          pstart  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    running  = (state_q != IDLE);
    counting = (state_q == STOP) || (state_q == RUN && !start_q);
  end

  always_comb begin
    load_ok  = div_load && (div_ratio >= DIV_W'(2));
    apply    = pend_v_q && (pstart || (state_q == IDLE && en));
    act_d    = apply ? pend_q : act_q;
    pend_d   = load_ok ? div_ratio : pend_q;
    pend_v_d = load_ok ? 1'b1 : (apply ? 1'b0 : pend_v_q);
    err_d    = div_load && !load_ok;
    tick_d   = pstart;
    cnt_d    = (counting && !wrap) ? cnt_q + DIV_W'(1) : '0;
    // high phase uses the ratio of the period being entered
    pos_d    = (pstart || (counting && !wrap)) && (cnt_d < (act_d >> 1));
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      pos_q    <= 1'b0;
      tick_q   <= 1'b0;
      act_q    <= DIV_W'(DEFAULT_DIV);
      pend_q   <= DIV_W'(DEFAULT_DIV);
      pend_v_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      tick_q   <= tick_d;
      act_q    <= act_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      err_q    <= err_d;
    end
  end

`ifdef CLKDIV_NEGEDGE_EN
  logic neg_q, neg_d;
  assign neg_d = pos_q;

  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= neg_d;
  end

  // odd ratios stretch the high phase by half a reference cycle
  assign clk_out = act_q[0] ? (pos_q | neg_q) : pos_q;
`else
  assign clk_out = pos_q;
`endif

  assign period_tick = tick_q;
  assign div_active  = act_q;
  assign cfg_pending = pend_v_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Randomized and directed bench for clk_divider_prog against a period-level reference model.
module tb_clk_divider_prog;

  localparam int DIV_W = 8;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             en = 1'b0;
  logic             div_load = 1'b0;
  logic [DIV_W-1:0] div_ratio = '0;
  logic             clk_out, period_tick, cfg_pending, cfg_err, running;
  logic [DIV_W-1:0] div_active;

  int total = 0;
  int bad   = 0;

  clk_divider_prog #(.DIV_W(DIV_W), .DEFAULT_DIV(5)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .div_load(div_load), .div_ratio(div_ratio),
    .clk_out(clk_out), .period_tick(period_tick), .div_active(div_active),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err), .running(running)
  );

  always #5 clk_in = ~clk_in;

  wire [DIV_W+4:0] obs = {clk_out, period_tick, div_active, cfg_pending, cfg_err, running};

  // Reference model: mode 0 idle, 1 entered RUN awaiting first period, 2 inside a period.
  // m_phase is the number of whole reference cycles since the current period began.
  int               m_mode = 0;
  int               m_phase = 0;
  int               m_n = 5;
  logic [DIV_W-1:0] m_act = 8'd5;
  logic [DIV_W-1:0] m_pend = 8'd5;
  bit               m_pend_v = 0;
  bit               m_err = 0;
  bit               m_tick = 0;
  bit               m_start;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_phase = 0; m_n = 5; m_act = 8'd5; m_pend = 8'd5;
      m_pend_v = 0; m_err = 0; m_tick = 0;
    end else begin
      m_start = 0;
      if (m_mode == 0) begin
        if (en) begin
          m_mode = 1;
          if (m_pend_v) begin m_act = m_pend; m_pend_v = 0; end
        end
      end else if (m_mode == 1) begin
        if (en) m_start = 1; else m_mode = 0;
      end else begin
        if (m_phase + 1 == m_n) begin
          if (en) m_start = 1; else m_mode = 0;
        end else begin
          m_phase++;
        end
      end
      if (m_start) begin
        if (m_pend_v) begin m_act = m_pend; m_pend_v = 0; end
        m_mode = 2; m_phase = 0; m_n = int'(m_act);
      end
      m_tick = m_start;
      m_err = 0;
      if (div_load) begin
        if (div_ratio >= 2) begin m_pend = div_ratio; m_pend_v = 1; end
        else m_err = 1;
      end
    end
  end

  function automatic bit exp_clk(input bit second_half);
    int h;
    if (m_mode != 2) return 1'b0;
    h = m_n / 2;
    if (m_phase < h) return 1'b1;
`ifdef CLKDIV_NEGEDGE_EN
    if ((m_n % 2 == 1) && m_phase == h && !second_half) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [DIV_W+4:0] exp_vec(input bit second_half);
    return {exp_clk(second_half), m_tick, m_act, m_pend_v, m_err, m_mode != 0};
  endfunction

  task automatic test_reset();
    logic [DIV_W+4:0] rst_exp;
    rst_exp = {1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0};
    rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_ratio = '0;
    repeat (3) @(posedge clk_in);
    #1; total++;
    if (obs !== rst_exp) begin bad++; $display("FAIL reset_state got=%h want=%h", obs, rst_exp); end
    @(negedge clk_in); rst_n = 1'b1;
  endtask

  task automatic test_default_run();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in); en = 1'b1; div_load = 1'b0;
      #1; total++;
      if (obs !== exp_vec(1'b1)) begin bad++; $display("FAIL default_run cyc=%0d got=%h want=%h", i, obs, exp_vec(1'b1)); end
      @(posedge clk_in); #1; total++;
      if (obs !== exp_vec(1'b0)) begin bad++; $display("FAIL default_run cyc=%0d got=%h want=%h", i, obs, exp_vec(1'b0)); end
    end
  endtask

  task automatic test_load_mid();
    for (int i = 0; i < 22; i++) begin
      @(negedge clk_in); en = 1'b1; div_load = (i == 2); div_ratio = 8'd4;
      #1; total++;
      if (obs !== exp_vec(1'b1)) begin bad++; $display("FAIL load_mid cyc=%0d got=%h want=%h", i, obs, exp_vec(1'b1)); end
      @(posedge clk_in); #1; total++;
      if (obs !== exp_vec(1'b0)) begin bad++; $display("FAIL load_mid cyc=%0d got=%h want=%h", i, obs, exp_vec(1'b0)); end
    end
  endtask

  task automatic test_double_load();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk_in); en = 1'b1; div_load = (i == 1 || i == 2); div_ratio = (i == 1) ? 8'd6 : 8'd3;
      #1; total++;
      if (obs !== exp_vec(1'b1)) begin bad++; $display("FAIL double_load cyc=%0d got=%h want=%h", i, obs, exp_vec(1'b1)); end
      @(posedge clk_in); #1; total++;
      if (obs !== exp_vec(1'b0)) begin bad++; $display("FAIL double_load cyc=%0d got=%h want=%h", i, obs, exp_vec(1'b0)); end
    end
  endtask

  task automatic test_bad_load();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk_in); en = 1'b1; div_load = (i == 1 || i == 6 || i == 9);
      div_ratio = (i == 1) ? 8'd1 : (i == 6) ? 8'd5 : 8'd0;
      #1; total++;
      if (obs !== exp_vec(1'b1)) begin bad++; $display("FAIL bad_load cyc=%0d got=%h want=%h", i, obs, exp_vec(1'b1)); end
      @(posedge clk_in); #1; total++;
      if (obs !== exp_vec(1'b0)) begin bad++; $display("FAIL bad_load cyc=%0d got=%h want=%h", i, obs, exp_vec(1'b0)); end
    end
  endtask

  task automatic test_stop_restart();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in); en = !(i >= 13 && i < 24) && !(i == 32); div_load = (i == 0); div_ratio = 8'd5;
      #1; total++;
      if (obs !== exp_vec(1'b1)) begin bad++; $display("FAIL stop_restart cyc=%0d got=%h want=%h", i, obs, exp_vec(1'b1)); end
      @(posedge clk_in); #1; total++;
      if (obs !== exp_vec(1'b0)) begin bad++; $display("FAIL stop_restart cyc=%0d got=%h want=%h", i, obs, exp_vec(1'b0)); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk_in);
      if ($urandom_range(0, 19) == 0) en = ~en;
      div_load = ($urandom_range(0, 11) == 0);
      div_ratio = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 12));
      #1; total++;
      if (obs !== exp_vec(1'b1)) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp_vec(1'b1)); end
      @(posedge clk_in); #1; total++;
      if (obs !== exp_vec(1'b0)) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp_vec(1'b0)); end
    end
  endtask

  task automatic test_reset_mid_high();
    int waited;
    logic [DIV_W+4:0] rst_exp;
    rst_exp = {1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0};
    @(negedge clk_in); en = 1'b1; div_load = 1'b1; div_ratio = 8'd7;
    @(negedge clk_in); div_load = 1'b0;
    waited = 0;
    while (!(m_mode == 2 && m_act == 8'd7 && m_phase == 1) && waited < 600) begin
      @(posedge clk_in); #1; waited++;
    end
    total++;
    if (waited >= 600) begin
      bad++; $display("FAIL reset_mid_wait timeout got=%0d want=<600", waited);
    end else begin
      total++;
      if (clk_out !== 1'b1) begin bad++; $display("FAIL reset_mid_pre got=%b want=1", clk_out); end
      #2 rst_n = 1'b0;
      #1; total++;
      if (obs !== rst_exp) begin bad++; $display("FAIL reset_mid_low got=%h want=%h", obs, rst_exp); end
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_in); #1; total++;
      if (obs !== exp_vec(1'b0)) begin bad++; $display("FAIL reset_restart cyc=%0d got=%h want=%h", i, obs, exp_vec(1'b0)); end
      @(negedge clk_in); #1; total++;
      if (obs !== exp_vec(1'b1)) begin bad++; $display("FAIL reset_restart cyc=%0d got=%h want=%h", i, obs, exp_vec(1'b1)); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_default_run();
    test_load_mid();
    test_double_load();
    test_bad_load();
    test_stop_restart();
    test_random();
    test_reset_mid_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
